// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit_if
// Brief    : Request/result bundle between the EX stage and the HI/LO engine.
// Revision : 1.0
// ============================================================================
interface ex_muldiv_unit_if #(
   parameter int DATA_BITS = 32
) ();
   logic                 flush;
   logic                 start;
   logic [1:0]           op;
   logic [DATA_BITS-1:0] src_a;
   logic [DATA_BITS-1:0] src_b;
   logic                 wr_hi;
   logic                 wr_lo;
   logic [DATA_BITS-1:0] wr_data;
   logic                 busy;
   logic                 done;
   logic [DATA_BITS-1:0] hi;
   logic [DATA_BITS-1:0] lo;

   modport master (
      output flush, start, op, src_a, src_b, wr_hi, wr_lo, wr_data,
      input  busy, done, hi, lo
   );

   modport slave (
      input  flush, start, op, src_a, src_b, wr_hi, wr_lo, wr_data,
      output busy, done, hi, lo
   );
endinterface

`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Brief    : Iterative radix-2 MULT/MULTU/DIV/DIVU engine owning HI/LO.
//            Define MULDIV_EARLY_OUT_EN to let multiplies finish early.
// Revision : 1.0
// ============================================================================
module ex_muldiv_unit #(
   parameter int DATA_BITS = 32
) (
   input  wire logic       clk,
   input  wire logic       rst,
   ex_muldiv_unit_if.slave bus
);
   localparam int c_n  = DATA_BITS;
   localparam int c_cw = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [c_cw-1:0] c_last = c_cw'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_cw-1:0]    r_count;
   logic [2*c_n-1:0]   r_acc;
   logic [2*c_n-1:0]   r_mc2;
   logic [c_n-1:0]     r_b;
   logic [c_n-1:0]     r_hi;
   logic [c_n-1:0]     r_lo;
   logic               r_is_div;
   logic               r_dz;
   logic               r_qsign;
   logic               r_rsign;
   logic               r_done;

   logic               w_is_div;
   logic               w_signed;
   logic               w_sa;
   logic               w_sb;
   logic               w_dz;
   logic [c_n-1:0]     w_abs_a;
   logic [c_n-1:0]     w_abs_b;

   assign w_is_div = bus.op[1];
   assign w_signed = ~bus.op[0];
   assign w_sa     = w_signed & bus.src_a[c_n-1];
   assign w_sb     = w_signed & bus.src_b[c_n-1];
   assign w_abs_a  = w_sa ? (-bus.src_a) : bus.src_a;
   assign w_abs_b  = w_sb ? (-bus.src_b) : bus.src_b;
   assign w_dz     = w_is_div && (bus.src_b == '0);

   // Restoring divide: remainder lives in acc[2n-1:n], quotient shifts in at acc[0]
   logic [c_n:0]       w_rem_sh;
   logic [c_n:0]       w_trial;
   logic [2*c_n-1:0]   w_div_acc;
   logic [2*c_n-1:0]   w_mul_acc;

   assign w_rem_sh  = r_acc[2*c_n-1:c_n-1];
   assign w_trial   = w_rem_sh - {1'b0, r_mc2[c_n-1:0]};
   assign w_div_acc = w_trial[c_n] ? {r_acc[2*c_n-2:0], 1'b0}
                                   : {w_trial[c_n-1:0], r_acc[c_n-2:0], 1'b1};
   assign w_mul_acc = r_acc + (r_b[0] ? r_mc2 : '0);

   logic [c_n-1:0]     w_q;
   logic [c_n-1:0]     w_r;
   logic [2*c_n-1:0]   w_prod;
   logic [c_n-1:0]     w_fix_hi;
   logic [c_n-1:0]     w_fix_lo;

   assign w_q    = r_acc[c_n-1:0];
   assign w_r    = r_acc[2*c_n-1:c_n];
   assign w_prod = r_qsign ? (-r_acc) : r_acc;

   always_comb begin
      w_fix_hi = w_prod[2*c_n-1:c_n];
      w_fix_lo = w_prod[c_n-1:0];
      if (r_dz) begin
         w_fix_hi = w_r;
         w_fix_lo = w_q;
      end else if (r_is_div) begin
         w_fix_hi = r_rsign ? (-w_r) : w_r;
         w_fix_lo = r_qsign ? (-w_q) : w_q;
      end
   end

   logic w_calc_last;
`ifdef MULDIV_EARLY_OUT_EN
   assign w_calc_last = (r_count == c_last) || (!r_is_div && (r_b[c_n-1:1] == '0));
`else
   assign w_calc_last = (r_count == c_last);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = w_dz ? S_FIX : S_CALC;
         S_CALC:  if (w_calc_last) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (bus.flush) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count  <= '0;
         r_acc    <= '0;
         r_mc2    <= '0;
         r_b      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_is_div <= 1'b0;
         r_dz     <= 1'b0;
         r_qsign  <= 1'b0;
         r_rsign  <= 1'b0;
         r_done   <= 1'b0;
      end else if (bus.flush) begin
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == S_FIX);
         if (bus.wr_hi) r_hi <= bus.wr_data;
         if (bus.wr_lo) r_lo <= bus.wr_data;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_count  <= '0;
                  r_is_div <= w_is_div;
                  r_dz     <= w_dz;
                  r_qsign  <= w_sa ^ w_sb;
                  r_rsign  <= w_sa;
                  if (w_is_div) begin
                     r_acc <= w_dz ? {bus.src_a, {c_n{1'b1}}} : {{c_n{1'b0}}, w_abs_a};
                     r_mc2 <= {{c_n{1'b0}}, w_abs_b};
                     r_b   <= '0;
                  end else begin
                     r_acc <= '0;
                     r_mc2 <= {{c_n{1'b0}}, w_abs_a};
                     r_b   <= w_abs_b;
                  end
               end
            end
            S_CALC: begin
               r_count <= r_count + c_cw'(1);
               if (r_is_div) begin
                  r_acc <= w_div_acc;
               end else begin
                  r_acc <= w_mul_acc;
                  r_mc2 <= r_mc2 << 1;
                  r_b   <= r_b >> 1;
               end
            end
            S_FIX: begin
               // Placed after the MTHI/MTLO writes so the result wins
               r_hi <= w_fix_hi;
               r_lo <= w_fix_lo;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (r_state != S_IDLE);
   assign bus.done = r_done;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;
endmodule

`default_nettype wire
